// File: rtl/spwm_deadtime_modulator.sv
// Regular-sampled SPWM comparator with dead-time insertion for one half-bridge leg.
// The reference is latched at carrier extrema, compared against the delayed
// carrier, and the raw PWM is turned into a complementary gate pair that never
// overlaps and always leaves DEAD_CYCLES of both-off time between conductions.
module spwm_deadtime_modulator #(
  parameter int MAX_A       = 128,
  parameter int DEAD_CYCLES = 8,
  parameter int SAMPLE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [$clog2(MAX_A)-1:0] carrier,
  input  logic [$clog2(MAX_A)-1:0] reference,
  output logic                     pwm_raw,
  output logic                     gate_hi,
  output logic                     gate_lo,
  output logic                     sample_strobe
);

  localparam int AW = $clog2(MAX_A);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DT_LOAD = DW'(DEAD_CYCLES - 1);
  localparam bit SAMPLE_PEAKS = (SAMPLE_MODE == 1);

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  typedef enum logic [2:0] {
    OFF,
    DT_HI,
    HI_ON,
    DT_LO,
    LO_ON
  } state_t;

  logic [AW-1:0] carrier_q;
  logic [AW-1:0] carrier_prev;
  logic [AW-1:0] ref_held;
  dir_t          dir;
  logic          valley;
  logic          peak;
  logic          take_sample;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] dt_cnt;
  logic [DW-1:0] dt_next;

  // Turnaround detection; a held (equal) carrier value is neither rising nor falling.
  always_comb begin
    valley      = (dir == DOWN) && (carrier_q > carrier_prev);
    peak        = (dir == UP) && (carrier_q < carrier_prev);
    take_sample = valley || (SAMPLE_PEAKS && peak);
  end

  // Carrier pipeline, direction tracking, reference latch and raw comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      carrier_q     <= '0;
      carrier_prev  <= '0;
      ref_held      <= '0;
      dir           <= UP;
      sample_strobe <= 1'b0;
      pwm_raw       <= 1'b0;
    end else begin
      carrier_q     <= carrier;
      carrier_prev  <= carrier_q;
      if (valley) begin
        dir <= UP;
      end else if (peak) begin
        dir <= DOWN;
      end
      if (take_sample) begin
        ref_held <= reference;
      end
      sample_strobe <= take_sample;
      pwm_raw       <= (ref_held > carrier_q);
    end
  end

  // Dead-time sequencing; a request that flips back during a dead interval
  // returns straight to the side that was never switched on.
  always_comb begin
    state_next = state;
    dt_next    = dt_cnt;
    if (!enable) begin
      state_next = OFF;
    end else begin
      case (state)
        OFF: begin
          state_next = pwm_raw ? DT_HI : DT_LO;
          dt_next    = DT_LOAD;
        end
        DT_HI: begin
          if (!pwm_raw) begin
            state_next = LO_ON;
          end else if (dt_cnt == '0) begin
            state_next = HI_ON;
          end else begin
            dt_next = dt_cnt - DW'(1);
          end
        end
        DT_LO: begin
          if (pwm_raw) begin
            state_next = HI_ON;
          end else if (dt_cnt == '0) begin
            state_next = LO_ON;
          end else begin
            dt_next = dt_cnt - DW'(1);
          end
        end
        HI_ON: begin
          if (!pwm_raw) begin
            state_next = DT_LO;
            dt_next    = DT_LOAD;
          end
        end
        LO_ON: begin
          if (pwm_raw) begin
            state_next = DT_HI;
            dt_next    = DT_LOAD;
          end
        end
        default: begin
          state_next = OFF;
        end
      endcase
    end
  end

  // State register with gates decoded from the next state so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= OFF;
      dt_cnt  <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      state   <= state_next;
      dt_cnt  <= dt_next;
      gate_hi <= (state_next == HI_ON);
      gate_lo <= (state_next == LO_ON);
    end
  end

endmodule

// File: tb/tb_spwm_deadtime_modulator.sv
// Testbench for spwm_deadtime_modulator: two instances (valley-only and
// valley+peak sampling) driven in parallel and compared against a behavioural model.
module tb_spwm_deadtime_modulator;

  localparam int MAX_A = 128;
  localparam int AW    = 7;
  localparam int DEAD  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] carrier = '0;
  logic [AW-1:0] reference = '0;
  logic [1:0]    pwm_v;
  logic [1:0]    hi_v;
  logic [1:0]    lo_v;
  logic [1:0]    stb_v;

  int checks = 0;
  int failures = 0;

  spwm_deadtime_modulator #(.MAX_A(MAX_A), .DEAD_CYCLES(DEAD), .SAMPLE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .carrier(carrier), .reference(reference),
    .pwm_raw(pwm_v[0]), .gate_hi(hi_v[0]), .gate_lo(lo_v[0]), .sample_strobe(stb_v[0])
  );

  spwm_deadtime_modulator #(.MAX_A(MAX_A), .DEAD_CYCLES(DEAD), .SAMPLE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .carrier(carrier), .reference(reference),
    .pwm_raw(pwm_v[1]), .gate_hi(hi_v[1]), .gate_lo(lo_v[1]), .sample_strobe(stb_v[1])
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural model: carrier history, direction, held reference, and a
  // gate rule expressed as request run lengths rather than a state machine.
  int m_cq = 0;
  int m_cp = 0;
  int m_ref[2];
  bit m_down[2];
  bit m_pwm[2];
  bit m_stb[2];
  int m_cond[2];
  int m_run[2];
  int m_prev_req[2];

  task automatic modelStep(input bit rst, input bit en, input int car, input int refv);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ref[i] = 0; m_down[i] = 0; m_pwm[i] = 0; m_stb[i] = 0;
        m_cond[i] = 0; m_run[i] = 0; m_prev_req[i] = 0;
      end else begin
        bit rising, falling, at_valley, at_peak, take;
        int req;
        rising    = m_cq > m_cp;
        falling   = m_cq < m_cp;
        at_valley = m_down[i] && rising;
        at_peak   = !m_down[i] && falling;
        take      = at_valley || (i == 1 && at_peak);
        if (!en) begin
          m_cond[i] = 0; m_run[i] = 0; m_prev_req[i] = 0;
        end else begin
          req = m_pwm[i] ? 1 : 2;
          m_run[i] = (req == m_prev_req[i]) ? m_run[i] + 1 : 1;
          if (m_cond[i] != req) begin
            if (m_cond[i] != 0) m_cond[i] = 0;
            else if (m_prev_req[i] != 0 && m_prev_req[i] != req) m_cond[i] = req;
            else if (m_run[i] > DEAD) m_cond[i] = req;
          end
          m_prev_req[i] = req;
        end
        m_pwm[i] = m_ref[i] > m_cq;
        if (take) m_ref[i] = refv;
        m_stb[i] = take;
        if (at_valley) m_down[i] = 0;
        else if (at_peak) m_down[i] = 1;
      end
    end
    if (rst) begin
      m_cq = 0; m_cp = 0;
    end else begin
      m_cp = m_cq; m_cq = car;
    end
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("pwm_raw[%0d]", i), pwm_v[i], m_pwm[i]);
      checkOutput($sformatf("sample_strobe[%0d]", i), stb_v[i], m_stb[i]);
      checkOutput($sformatf("gate_hi[%0d]", i), hi_v[i], m_cond[i] == 1);
      checkOutput($sformatf("gate_lo[%0d]", i), lo_v[i], m_cond[i] == 2);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic applyStimulus(input bit rst, input bit en, input int car, input int refv);
    reset = rst; enable = en; carrier = AW'(car); reference = AW'(refv);
    @(posedge clk);
    modelStep(rst, en, car, refv);
    #1;
    checkModel();
  endtask

  // Dead-time monitor on the valley-sampled instance.
  logic en_edge = 1'b0;
  logic rst_edge = 1'b1;
  int   last_side = 0;
  int   low_run = 0;
  bit   interrupted = 0;

  // Capture the control inputs that applied at each edge.
  always @(posedge clk) begin
    en_edge  <= enable;
    rst_edge <= reset;
  end

  // Check non-overlap every cycle and the both-off interval at each side change.
  always @(negedge clk) begin
    int cur;
    if (rst_edge) begin
      last_side = 0; low_run = 0; interrupted = 0;
    end else begin
      checkOutput("gate_overlap", hi_v[0] & lo_v[0], 1'b0);
      if (!en_edge) interrupted = 1;
      if (hi_v[0] || lo_v[0]) begin
        cur = hi_v[0] ? 1 : 2;
        if (last_side != 0 && cur != last_side) begin
          if (interrupted) checkOutput("dead_time_min", low_run >= DEAD, 1'b1);
          else checkCount("dead_time_exact", low_run, DEAD);
        end
        last_side = cur; low_run = 0; interrupted = 0;
      end else begin
        low_run++;
      end
    end
  end

  typedef struct {
    bit rst;
    int car;
    int refv;
    bit stb;
    bit pwm;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cnt_a, cnt_b, cnt_c;
    int c, up, step, hold, rv;
    bit en_r;

    // Sampling/comparison vectors for the valley-only instance, gates disabled.
    vecs[0]  = '{1, 0, 0, 0, 0};
    vecs[1]  = '{0, 10, 50, 0, 0};
    vecs[2]  = '{0, 20, 50, 0, 0};
    vecs[3]  = '{0, 15, 50, 0, 0};
    vecs[4]  = '{0, 5, 50, 0, 0};
    vecs[5]  = '{0, 5, 50, 0, 0};
    vecs[6]  = '{0, 9, 50, 0, 0};
    vecs[7]  = '{0, 30, 60, 1, 0};
    vecs[8]  = '{0, 70, 0, 0, 1};
    vecs[9]  = '{0, 60, 0, 0, 0};
    vecs[10] = '{0, 50, 0, 0, 0};
    vecs[11] = '{0, 51, 5, 0, 1};
    vecs[12] = '{0, 51, 5, 1, 1};
    vecs[13] = '{0, 51, 5, 0, 0};
    vecs[14] = '{1, 51, 5, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0};

    for (int k = 0; k < 16; k++) begin
      applyStimulus(vecs[k].rst, 0, vecs[k].car, vecs[k].refv);
      checkOutput($sformatf("vec%0d_strobe", k), stb_v[0], vecs[k].stb);
      checkOutput($sformatf("vec%0d_pwm", k), pwm_v[0], vecs[k].pwm);
      checkOutput($sformatf("vec%0d_gates", k), hi_v[0] | lo_v[0], 1'b0);
    end

    // reference=0: low side conducts after exactly DEAD both-off cycles.
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput($sformatf("ref0_lo_k%0d", k), lo_v[0], k >= DEAD);
      checkOutput($sformatf("ref0_hi_k%0d", k), hi_v[0], 1'b0);
    end

    // Latch reference=127 at a valley with gates off, then enable towards the high side.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 20, 127);
    applyStimulus(0, 0, 10, 127);
    applyStimulus(0, 0, 10, 127);
    applyStimulus(0, 0, 20, 127);
    applyStimulus(0, 0, 20, 127);
    applyStimulus(0, 0, 20, 127);
    checkOutput("ref127_pwm", pwm_v[0], 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 20, 127);
      checkOutput($sformatf("en_hi_k%0d", k), hi_v[0], k >= DEAD);
    end

    // Two-cycle pwm_raw dip while conducting high: brief DT_LO, low side never fires.
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, (k < 2) ? 127 : 20, 127);
      if (lo_v[0]) cnt_a++;
      if (!hi_v[0]) cnt_b++;
    end
    checkCount("glitch_lo_count", cnt_a, 0);
    checkCount("glitch_hi_gap", cnt_b, 2);

    // Enable drop while conducting, then re-enable through a full dead interval.
    applyStimulus(0, 0, 20, 127);
    checkOutput("disable_hi", hi_v[0], 1'b0);
    checkOutput("disable_lo", lo_v[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 20, 127);
      checkOutput($sformatf("reen_hi_k%0d", k), hi_v[0], k >= DEAD);
    end

    // Reset in the middle of a dead interval.
    applyStimulus(0, 0, 20, 127);
    applyStimulus(0, 1, 20, 127);
    applyStimulus(0, 1, 20, 127);
    applyStimulus(1, 1, 20, 127);
    checkOutput("rst_pwm", pwm_v[0], 1'b0);
    checkOutput("rst_strobe", stb_v[0], 1'b0);
    checkOutput("rst_hi", hi_v[0], 1'b0);
    checkOutput("rst_lo", lo_v[0], 1'b0);
    applyStimulus(0, 1, 20, 127);
    checkOutput("post_rst_pwm", pwm_v[0], 1'b0);

    // Full step-1 sweep with reference=64: half duty, one or two samples per period.
    applyStimulus(1, 0, 0, 64);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int p = 0; p < 3; p++) begin
      for (int idx = 0; idx < 254; idx++) begin
        applyStimulus(0, 1, (idx <= 127) ? idx : 254 - idx, 64);
        if (p == 2) begin
          if (pwm_v[0]) cnt_a++;
          if (stb_v[0]) cnt_b++;
          if (stb_v[1]) cnt_c++;
        end
      end
    end
    checkCount("sweep_duty", cnt_a, 127);
    checkCount("sweep_strobes_valley", cnt_b, 1);
    checkCount("sweep_strobes_both", cnt_c, 2);

    // Randomized carrier steps, turnaround holds, references, enable and reset.
    applyStimulus(1, 0, 0, 0);
    c = 0; up = 1; step = 3; hold = 0; en_r = 1;
    for (int n = 0; n < 3000; n++) begin
      if (hold != 0) begin
        hold = 0;
      end else if (up != 0) begin
        if (c + step >= MAX_A - 1) begin
          c = MAX_A - 1; up = 0; hold = $urandom_range(0, 1); step = $urandom_range(1, 9);
        end else begin
          c = c + step;
        end
      end else begin
        if (c - step <= 0) begin
          c = 0; up = 1; hold = $urandom_range(0, 1); step = $urandom_range(1, 9);
        end else begin
          c = c - step;
        end
      end
      if ($urandom_range(0, 9) == 0) rv = ($urandom_range(0, 1) != 0) ? MAX_A - 1 : 0;
      else rv = $urandom_range(0, MAX_A - 1);
      if ($urandom_range(0, 199) == 0) en_r = !en_r;
      applyStimulus($urandom_range(0, 499) == 0, en_r, c, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
